fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
Parametrised next-generation fetch stage for the 5-stage MIPS pipeline. It drives a synchronous-read instruction memory (1-cycle read latency), buffers fetched words in a DEPTH-entry prefetch FIFO, and presents one instruction per cycle to the IF/ID latch. It sits between the instruction memory core and the IF/ID latch. Compared with the single-register PC fetch, it adds a decoupling queue, credit-based issue, and squashing of in-flight reads on a branch redirect.

Parameters:
ADDR_W, 9, width of PC and instruction-memory address
DATA_W, 32, instruction word width
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
PC_INC, 1, PC increment per sequential fetch (memory is word-addressed)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
inicio  in  1  reset, asynchronous, active-high
mem_en  out  1  instruction-memory read enable
mem_addr  out  ADDR_W  instruction-memory read address
mem_rdata  in  DATA_W  read data; valid exactly one cycle after mem_en=1
stall_d  in  1  consumer hold; head entry is not popped while 1
redirect  in  1  taken branch (PCSrcD); flushes queue and retargets PC
redirect_pc  in  ADDR_W  branch target (PCBranchD)
instr_valid  out  1  head entry valid
instr_out  out  DATA_W  head instruction
pc_plus_out  out  ADDR_W  head instruction address + PC_INC (PCPlus4 equivalent)
occupancy  out  clog2(DEPTH+1)  current number of FIFO entries

Behaviour:
- Reset (asynchronous assert, synchronous-edge release): PC=RESET_PC, mem_en=0, mem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_plus_out=0, occupancy=0, in-flight flag=0, read/write pointers=0. Reset mid-operation discards all entries and any in-flight read.
- Issue: mem_en and mem_addr are combinational from state. mem_en=1 when (occupancy + inflight) < DEPTH and redirect=0. mem_addr=PC. On an issuing edge: PC<=PC+PC_INC (wraps modulo 2^ADDR_W), inflight<=1, and the issued address is stored with the request. With no issue, inflight<=0 and PC holds.
- Return: while inflight=1 and not squashed, mem_rdata and (issued address + PC_INC) are written at the FIFO tail on the edge that ends that cycle.
- Latency: reset release at edge 0. Edge 0 is the first issue, with mem_addr=RESET_PC during cycle 0. Data arrives in cycle 1 and is pushed on edge 1. instr_valid=1 in cycle 2. There is no bypass from mem_rdata to instr_out.
- Output: instr_valid = occupancy>0. instr_out and pc_plus_out show the head entry and are 0 when empty.
- Pop: on an edge with instr_valid=1, stall_d=0 and redirect=0.
- Simultaneous push and pop: both happen and occupancy is unchanged.
- Full: the credit rule guarantees no push ever reaches a full FIFO. With occupancy=DEPTH, mem_en=0 and PC holds.
- Empty: no pop, regardless of stall_d.
- Redirect (priority over push, pop and issue):
  - On the redirect edge, the FIFO empties (pointers reset, occupancy=0) and PC<=redirect_pc.
  - Any read issued in the previous cycle is squashed, so its data is never pushed.
  - mem_en=0 during the redirect cycle.
  - The first issue at redirect_pc happens in the cycle after redirect, and the target instruction is valid 2 cycles after that issue.
- Back-to-back redirects: the last one wins.
- redirect while inicio=1: ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter.

Test Plan:
- Reset then free-run, with mem model mem[a]=a*16+3, DEPTH=4 and stall_d=0: instr_valid first high in cycle 2 with instr_out=3 and pc_plus_out=1. After that, one instruction per cycle with consecutive values 19, 35, …
- Hold stall_d=1 from cycle 2: occupancy climbs to 4 and stays there, mem_en=0 once occupancy+inflight=4, and PC holds at 4. Release stall_d: entries 3, 19, 35, 51 pop in order and no word is lost or duplicated.
- redirect=1 with redirect_pc=0x40 while occupancy=3 and a read is in flight: next cycle occupancy=0, instr_valid=0, mem_en=1 with mem_addr=0x40. The squashed word never appears, and the first output is mem[0x40] with pc_plus_out=0x41.
- redirect coincident with stall_d=0 and a valid head: the head is not popped as a new instruction, the FIFO is flushed, and occupancy=0 on the next cycle.
- PC wrap, with RESET_PC=0x1FE and ADDR_W=9: fetch addresses run 0x1FE, 0x1FF, 0x000, and pc_plus_out for address 0x1FF equals 0x000.
- Assert inicio asynchronously mid-stream with occupancy=2: all outputs go to reset values immediately without a clock edge, and after release the fetch sequence restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a prefetch FIFO between a synchronous-read instruction
// memory (1-cycle latency) and the IF/ID latch. Reads are issued only when a
// FIFO slot is guaranteed for the returning word, so a push never hits a full
// queue. A redirect flushes the queue, retargets the PC and drops the
// in-flight read.
//
// Consumer handshake: the head entry is offered while instr_valid=1. It is
// taken on a rising edge where instr_valid=1, stall_d=0 and redirect=0. It is
// held otherwise. instr_out/pc_plus_out read 0 while the queue is empty.
module fetch_prefetch_queue #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = 1,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       inicio,
    output logic                       mem_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       stall_d,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr_out,
    output logic [ADDR_W-1:0]          pc_plus_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_INC_C   = ADDR_W'(PC_INC);
    localparam logic [OCC_W:0]    DEPTH_C    = (OCC_W+1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] reqAddr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [OCC_W-1:0]  occ;

    logic [DATA_W-1:0] fifoData [DEPTH];
    logic [ADDR_W-1:0] fifoPc   [DEPTH];

    logic [OCC_W:0] credit;
    logic           issue;
    logic           push;
    logic           pop;

    // Issue/push/pop decisions; redirect overrides all three.
    always_comb begin
        credit = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        issue  = !inicio && !redirect && (credit < DEPTH_C);
        push   = inflight && !redirect;
        pop    = (occ != '0) && !stall_d && !redirect;
    end

    assign mem_en      = issue;
    assign mem_addr    = pc;
    assign occupancy   = occ;
    assign instr_valid = (occ != '0);
    assign instr_out   = instr_valid ? fifoData[rdPtr] : '0;
    assign pc_plus_out = instr_valid ? fifoPc[rdPtr]   : '0;

    // PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            pc       <= RESET_PC_C;
            inflight <= 1'b0;
            reqAddr  <= RESET_PC_C;
            rdPtr    <= '0;
            wrPtr    <= '0;
            occ      <= '0;
        end else if (redirect) begin
            // The read returning this cycle belongs to the old path: drop it.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            occ      <= '0;
        end else begin
            if (issue) begin
                pc      <= pc + PC_INC_C;
                reqAddr <= pc;
            end
            inflight <= issue;
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Queue storage; contents past the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoData[wrPtr] <= mem_rdata;
            fifoPc[wrPtr]   <= reqAddr + PC_INC_C;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus a random phase,
// checked every cycle against a queue-based reference of the fetch stage.
module tb_fetch_prefetch_queue;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    // clock / reset
    logic clk    = 1'b0;
    logic inicio = 1'b1;
    always #5 clk = ~clk;

    logic              stall_d     = 1'b0;
    logic              redirect    = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] pc_plus_out;
    logic [2:0]        occupancy;

    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata = '0;
    logic              w_valid;
    logic [DATA_W-1:0] w_out;
    logic [ADDR_W-1:0] w_pcp;
    logic [2:0]        w_occ;

    fetch_prefetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                           .PC_INC(1), .RESET_PC(0)) dut (
        .clk(clk), .inicio(inicio), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .stall_d(stall_d), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_out(instr_out), .pc_plus_out(pc_plus_out), .occupancy(occupancy)
    );

    fetch_prefetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                           .PC_INC(1), .RESET_PC(9'h1FE)) u_wrap (
        .clk(clk), .inicio(inicio), .mem_en(w_en), .mem_addr(w_addr),
        .mem_rdata(w_rdata), .stall_d(1'b0), .redirect(1'b0),
        .redirect_pc(9'd0), .instr_valid(w_valid),
        .instr_out(w_out), .pc_plus_out(w_pcp), .occupancy(w_occ)
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'(a) * 32'd16 + 32'd3;
    endfunction

    // instruction memories: 1-cycle read, garbage when not enabled
    always @(posedge clk) mem_rdata <= mem_en ? mem_word(mem_addr) : $urandom;
    always @(posedge clk) w_rdata   <= w_en   ? mem_word(w_addr)   : $urandom;

    // scoreboard / reference model
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_pc_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic              m_pend;
    logic [ADDR_W-1:0] m_pend_addr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_en();
        return !inicio && !redirect && ((exp_q.size() + int'(m_pend)) < DEPTH);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_pc_q.delete();
        m_pc        = '0;
        m_pend      = 1'b0;
        m_pend_addr = '0;
    endtask

    // one rising edge of the reference: redirect > (pop, push, issue)
    task automatic model_edge();
        logic en;
        en = model_en();
        if (inicio) begin
            model_reset();
        end else if (redirect) begin
            exp_q.delete();
            exp_pc_q.delete();
            m_pc   = redirect_pc;
            m_pend = 1'b0;
        end else begin
            if (exp_q.size() > 0 && !stall_d) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (m_pend) begin
                exp_q.push_back(mem_word(m_pend_addr));
                exp_pc_q.push_back(m_pend_addr + 9'd1);
            end
            if (en) begin
                m_pend_addr = m_pc;
                m_pc        = m_pc + 9'd1;
            end
            m_pend = en;
        end
    endtask

    task automatic check_model();
        logic ev;
        ev = (exp_q.size() > 0);
        check("instr_valid", 32'(instr_valid), 32'(ev));
        check("instr_out",   instr_out,        ev ? exp_q[0] : 32'd0);
        check("pc_plus_out", 32'(pc_plus_out), ev ? 32'(exp_pc_q[0]) : 32'd0);
        check("occupancy",   32'(occupancy),   32'(exp_q.size()));
        check("mem_en",      32'(mem_en),      32'(model_en()));
        check("mem_addr",    32'(mem_addr),    32'(m_pc));
    endtask

    // driver tasks: drive at the falling edge, check 1ns later, then clock
    task automatic drive(input logic st, input logic rd, input logic [ADDR_W-1:0] rpc);
        stall_d     = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        check_model();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_seq();
        inicio = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        inicio = 1'b0;
    endtask

    logic [DATA_W-1:0] pop_tbl [4];

    initial begin
        pop_tbl[0] = 32'd3;
        pop_tbl[1] = 32'd19;
        pop_tbl[2] = 32'd35;
        pop_tbl[3] = 32'd51;
        model_reset();

        // reset values, then free run (plus PC wrap on the second instance)
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        check("rst_mem_en",   32'(mem_en),   32'd0);
        check("rst_w_addr",   32'(w_addr),   32'h1FE);
        check("rst_w_valid",  32'(w_valid),  32'd0);
        tick();
        inicio = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, '0);
            if (c == 0) check("wrap_addr0", 32'(w_addr), 32'h1FE);
            if (c == 1) check("wrap_addr1", 32'(w_addr), 32'h1FF);
            if (c == 2) begin
                check("first_valid", 32'(instr_valid), 32'd1);
                check("first_instr", instr_out, 32'd3);
                check("first_pcp",   32'(pc_plus_out), 32'd1);
                check("wrap_addr2",  32'(w_addr), 32'h000);
                check("wrap_out0",   w_out, 32'h1FE3);
                check("wrap_pcp0",   32'(w_pcp), 32'h1FF);
            end
            if (c == 3) begin
                check("second_instr", instr_out, 32'd19);
                check("wrap_out1",    w_out, 32'h1FF3);
                check("wrap_pcp1",    32'(w_pcp), 32'h000);
            end
            if (c == 4) begin
                check("wrap_out2", w_out, 32'h0003);
                check("wrap_pcp2", 32'(w_pcp), 32'h001);
            end
            tick();
        end

        // stall from cycle 2 until full, then drain in order
        reset_seq();
        for (int c = 0; c < 9; c++) begin
            drive(c >= 2, 1'b0, '0);
            if (c == 8) begin
                check("full_occ",  32'(occupancy), 32'd4);
                check("full_en",   32'(mem_en),    32'd0);
                check("full_addr", 32'(mem_addr),  32'd4);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, '0);
            check("drain_order", instr_out, pop_tbl[k]);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end

        // redirect with occupancy 3 and a read in flight
        reset_seq();
        for (int c = 0; c < 4; c++) begin
            drive(c >= 2, 1'b0, '0);
            tick();
        end
        drive(1'b1, 1'b1, 9'h040);
        check("redir_pre_occ", 32'(occupancy), 32'd3);
        tick();
        drive(1'b0, 1'b0, '0);
        check("redir_occ",   32'(occupancy),   32'd0);
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_en",    32'(mem_en),      32'd1);
        check("redir_addr",  32'(mem_addr),    32'h040);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        check("redir_target",  instr_out, 32'h403);
        check("redir_tgt_pcp", 32'(pc_plus_out), 32'h041);
        tick();

        // redirect with a valid head and stall_d=0, then back-to-back redirects
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b1, 9'h100);
        tick();
        drive(1'b0, 1'b0, '0);
        check("flush_occ", 32'(occupancy), 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b1, 9'h020);
        tick();
        drive(1'b0, 1'b1, 9'h080);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, '0);
            if (c == 2) begin
                check("b2b_target", instr_out, 32'h803);
                check("b2b_pcp",    32'(pc_plus_out), 32'h081);
            end
            tick();
        end

        // random stall / redirect traffic
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  ADDR_W'($urandom_range(0, 511)));
            tick();
        end

        // asynchronous reset mid-stream with occupancy 2
        reset_seq();
        for (int c = 0; c < 3; c++) begin
            drive(c >= 2, 1'b0, '0);
            tick();
        end
        drive(1'b1, 1'b0, '0);
        check("async_pre_occ", 32'(occupancy), 32'd2);
        #1;
        inicio = 1'b1;
        #1;
        model_reset();
        check_model();
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_occ",   32'(occupancy),   32'd0);
        check("async_out",   instr_out,        32'd0);
        check("async_en",    32'(mem_en),      32'd0);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        inicio = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, '0);
            if (c == 0) check("restart_addr",  32'(mem_addr), 32'd0);
            if (c == 2) check("restart_instr", instr_out, 32'd3);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
